reg_file_reader: RTL and testbench
==================================

Name: reg_file_reader

Overview:
- Debug/readback engine that reads the 16-bit registers written by the register-file load path.
- On a start pulse it steps a read-select through every register and samples each register output via the external read mux.
- Each word is emitted on a valid/ready stream tagged with its index, followed by a 16-bit XOR checksum word flagged last.
- Sits between the CPU register file and the debug/trace port.

Parameters:
- NREGS, 8: number of registers scanned; must be 2 or more.
- WIDTH, 16: register data width.
- IDXW, 3: width of the select/index fields; must satisfy 2^IDXW >= NREGS.

Ports:
- CLK  input  1  system clock; rising edge active.
- RST_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a scan; sampled only in IDLE.
- abort  input  1  synchronous cancel of the scan in progress.
- rd_sel  output  IDXW  register select driven to the read mux.
- rd_data  input  WIDTH  combinational mux output for rd_sel.
- out_data  output  WIDTH  stream data.
- out_idx  output  IDXW  index of the register in out_data (0 on the checksum word).
- out_last  output  1  marks the checksum word.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready from the sink.
- busy  output  1  high from the start-accept edge until scan end.
- done  output  1  one-cycle pulse after the checksum word is accepted.

Behaviour:
- One clock: CLK. Reset is asynchronous and active-low on RST_n; asserting it forces reset state immediately, independent of CLK.
- Reset state:
  - state=IDLE.
  - rd_sel=0, out_data=0, out_idx=0, out_last=0, out_valid=0, busy=0, done=0.
  - Internal checksum=0.
- States: IDLE, SETTLE, SEND, CSUM.
- IDLE:
  - start=1 at an edge -> SETTLE; rd_sel=0, busy=1, checksum=0.
  - start is ignored in every other state.
- SETTLE (exactly one cycle, lets rd_data settle through the mux):
  - Next edge: out_data=rd_data, out_idx=rd_sel, out_valid=1, checksum^=rd_data.
  - Go to SEND.
- SEND:
  - While out_valid=1 and out_ready=0: out_data, out_idx and out_last hold stable. rd_data changes are ignored.
  - Handshake (out_valid & out_ready at an edge), when rd_sel<NREGS-1: rd_sel+=1, out_valid=0, go to SETTLE.
  - Handshake when rd_sel==NREGS-1: out_data=checksum (already including the last word), out_idx=0, out_last=1, out_valid=1, go to CSUM. No idle cycle is inserted.
- CSUM:
  - Hold outputs until handshake.
  - On handshake: out_valid=0, out_last=0, busy=0, done=1 for one cycle, go to IDLE.
  - rd_sel stays at NREGS-1 until the next start.
- Latency:
  - First out_valid is visible 2 edges after start is sampled, i.e. the second edge counting the start-sampling edge.
  - With out_ready held at 1, the cadence is one data word per 2 cycles.
  - The checksum word follows the last data handshake on the next cycle.
  - A full scan with ready held high takes 2*NREGS+1 cycles from start-accept to done.
- abort:
  - abort=1 at an edge in any non-IDLE state -> IDLE.
  - out_valid=0, out_last=0, busy=0; done stays 0; checksum is cleared.
  - abort has priority over a simultaneous handshake: a word accepted on the abort edge counts as the final transfer, and no further words follow.
  - abort in IDLE has no effect. start and abort together in IDLE: start wins.
- RST_n low mid-scan: immediate return to the reset state; no done pulse.
- A new start is accepted no earlier than the edge after done; done and busy are never high together.
- Arithmetic: checksum is a WIDTH-bit bitwise XOR. rd_sel never exceeds NREGS-1, and no wrap-around occurs within a scan.
- out_valid never drops without a handshake, except on abort or reset.

Test Plan:
- Basic scan: NREGS=4, registers=0x1234,0xABCD,0x0000,0xFFFF, out_ready=1, start pulse -> words (0,0x1234), (1,0xABCD), (2,0x0000), (3,0xFFFF), then checksum 0x4606 with out_last=1. done pulses 9 cycles after the start-accept edge; busy is high throughout.
- Backpressure: same setup, out_ready low for 5 cycles while word 1 is presented -> out_data=0xABCD and out_idx=1 stay stable. Changing register 1 to 0x5555 during the stall does not alter out_data or the checksum (still 0x4606).
- Abort: abort asserted while word 2 is in SEND -> out_valid=0 and busy=0 next edge, no done, no checksum word. A following start restarts the scan from idx 0 with checksum 0x4606.
- Start ignored: start held high for the whole scan -> exactly one scan of 5 words. A second scan begins on the edge after done if start is still high.
- Async reset: RST_n pulled low mid-SEND between clock edges -> all outputs go to 0 immediately. After release, the block stays idle until start.
- Boundary: NREGS=2, registers=0xFFFF,0xFFFF -> checksum word 0x0000 with out_last=1. rd_sel never exceeds 1.

Source files
------------

// File: rtl/reg_file_reader.sv
// Debug readback engine: scans a register file through an external read mux and streams
// each word tagged with its index, followed by an XOR checksum word flagged last.
module reg_file_reader #(
    parameter int unsigned NREGS = 8,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDXW  = 3
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             start,
    input  logic             abort,
    output logic [IDXW-1:0]  rd_sel,
    input  logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] out_data,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StSettle, StSend, StCsum} state_e;

    localparam logic [IDXW-1:0] LastIdx = IDXW'(NREGS - 1);

    state_e           state;
    logic [WIDTH-1:0] checksum;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= StIdle;
            rd_sel    <= '0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            checksum  <= '0;
        end else begin
            done <= 1'b0;
            // Abort beats a same-edge handshake; the word accepted on this edge is the last one.
            if (abort && state != StIdle) begin
                state     <= StIdle;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                busy      <= 1'b0;
                checksum  <= '0;
            end else begin
                case (state)
                    StIdle: begin
                        if (start) begin
                            state    <= StSettle;
                            rd_sel   <= '0;
                            busy     <= 1'b1;
                            checksum <= '0;
                        end
                    end
                    StSettle: begin
                        out_data  <= rd_data;
                        out_idx   <= rd_sel;
                        out_valid <= 1'b1;
                        checksum  <= checksum ^ rd_data;
                        state     <= StSend;
                    end
                    StSend: begin
                        // out_valid is always high here, so ready alone completes the handshake.
                        if (out_ready) begin
                            if (rd_sel == LastIdx) begin
                                out_data <= checksum;
                                out_idx  <= '0;
                                out_last <= 1'b1;
                                state    <= StCsum;
                            end else begin
                                rd_sel    <= rd_sel + IDXW'(1);
                                out_valid <= 1'b0;
                                state     <= StSettle;
                            end
                        end
                    end
                    StCsum: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= StIdle;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reg_file_reader.sv
// Directed bench for reg_file_reader: a 4-register instance and a 2-register boundary instance.
module tb_reg_file_reader;

    logic CLK = 1'b0;
    logic RST_n = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // 4-register instance
    logic        start4 = 1'b0, abort4 = 1'b0, ready4 = 1'b1;
    logic [1:0]  sel4, idx4;
    logic [15:0] rd4, data4;
    logic        last4, valid4, busy4, done4;
    logic [15:0] regs4 [0:3];
    logic [15:0] exp4 [0:3];
    assign rd4 = regs4[sel4];

    reg_file_reader #(.NREGS(4), .WIDTH(16), .IDXW(2)) u4 (
        .CLK(CLK), .RST_n(RST_n), .start(start4), .abort(abort4),
        .rd_sel(sel4), .rd_data(rd4), .out_data(data4), .out_idx(idx4),
        .out_last(last4), .out_valid(valid4), .out_ready(ready4),
        .busy(busy4), .done(done4)
    );

    // 2-register instance
    logic        start2 = 1'b0, abort2 = 1'b0, ready2 = 1'b1;
    logic [1:0]  sel2, idx2;
    logic [15:0] rd2, data2;
    logic        last2, valid2, busy2, done2;
    logic [15:0] regs2 [0:3];
    assign rd2 = regs2[sel2];

    reg_file_reader #(.NREGS(2), .WIDTH(16), .IDXW(2)) u2 (
        .CLK(CLK), .RST_n(RST_n), .start(start2), .abort(abort2),
        .rd_sel(sel2), .rd_data(rd2), .out_data(data2), .out_idx(idx2),
        .out_last(last2), .out_valid(valid2), .out_ready(ready2),
        .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present word k of the 4-register scan (ready assumed high on the following edge).
    task automatic word4(input int k, input logic [15:0] d);
        tick();
        chk($sformatf("w%0d_valid", k), 32'(valid4), 32'd1);
        chk($sformatf("w%0d_idx", k), 32'(idx4), 32'(k));
        chk($sformatf("w%0d_data", k), 32'(data4), 32'(d));
        chk($sformatf("w%0d_last", k), 32'(last4), 32'd0);
        chk($sformatf("w%0d_busy", k), 32'(busy4), 32'd1);
    endtask

    // Full scan from the start-accept edge onward, ready held high.
    task automatic scan4(input string tag, input logic [15:0] csum);
        for (int k = 0; k < 4; k++) begin
            word4(k, exp4[k]);
            tick();
            if (k < 3) begin
                chk({tag, "_gap_valid"}, 32'(valid4), 32'd0);
            end else begin
                chk({tag, "_csum_valid"}, 32'(valid4), 32'd1);
                chk({tag, "_csum_last"}, 32'(last4), 32'd1);
                chk({tag, "_csum_idx"}, 32'(idx4), 32'd0);
                chk({tag, "_csum_data"}, 32'(data4), 32'(csum));
                chk({tag, "_csum_done"}, 32'(done4), 32'd0);
            end
        end
        tick();
        chk({tag, "_done"}, 32'(done4), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy4), 32'd0);
        chk({tag, "_valid_end"}, 32'(valid4), 32'd0);
        chk({tag, "_last_end"}, 32'(last4), 32'd0);
    endtask

    initial begin
        regs4[0] = 16'h1234; regs4[1] = 16'hABCD; regs4[2] = 16'h0000; regs4[3] = 16'hFFFF;
        exp4[0]  = 16'h1234; exp4[1]  = 16'hABCD; exp4[2]  = 16'h0000; exp4[3]  = 16'hFFFF;
        regs2[0] = 16'hFFFF; regs2[1] = 16'hFFFF; regs2[2] = 16'h0; regs2[3] = 16'h0;

        // Reset state
        #3;
        chk("rst_valid", 32'(valid4), 32'd0);
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_done", 32'(done4), 32'd0);
        chk("rst_sel", 32'(sel4), 32'd0);
        chk("rst_data", 32'(data4), 32'd0);
        tick();
        tick();
        RST_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy4), 32'd0);

        // Basic scan
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("b_busy_accept", 32'(busy4), 32'd1);
        chk("b_valid_accept", 32'(valid4), 32'd0);
        scan4("basic", 16'h4606);
        tick();
        chk("b_done_pulse", 32'(done4), 32'd0);
        chk("b_sel_hold", 32'(sel4), 32'd3);

        // Backpressure on word 1, register changes during the stall
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        word4(0, 16'h1234);
        tick();
        word4(1, 16'hABCD);
        ready4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) regs4[1] = 16'h5555;
            tick();
            chk("bp_valid", 32'(valid4), 32'd1);
            chk("bp_idx", 32'(idx4), 32'd1);
            chk("bp_data", 32'(data4), 32'hABCD);
        end
        ready4 = 1'b1;
        tick();
        chk("bp_hs_valid", 32'(valid4), 32'd0);
        word4(2, 16'h0000);
        tick();
        word4(3, 16'hFFFF);
        tick();
        chk("bp_csum_last", 32'(last4), 32'd1);
        chk("bp_csum_data", 32'(data4), 32'h4606);
        tick();
        chk("bp_done", 32'(done4), 32'd1);
        regs4[1] = 16'hABCD;
        tick();

        // Abort while word 2 is presented
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        word4(0, 16'h1234);
        tick();
        word4(1, 16'hABCD);
        tick();
        word4(2, 16'h0000);
        abort4 = 1'b1;
        tick();
        abort4 = 1'b0;
        chk("ab_valid", 32'(valid4), 32'd0);
        chk("ab_busy", 32'(busy4), 32'd0);
        chk("ab_done", 32'(done4), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ab_quiet_valid", 32'(valid4), 32'd0);
            chk("ab_quiet_done", 32'(done4), 32'd0);
        end
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        scan4("restart", 16'h4606);
        tick();

        // Start held high for the whole scan
        start4 = 1'b1;
        tick();
        scan4("held", 16'h4606);
        chk("held_busy_dn", 32'(busy4), 32'd0);
        tick();
        chk("held_rescan_busy", 32'(busy4), 32'd1);
        chk("held_rescan_done", 32'(done4), 32'd0);
        start4 = 1'b0;
        abort4 = 1'b1;
        tick();
        abort4 = 1'b0;
        chk("held_abort_busy", 32'(busy4), 32'd0);

        // Asynchronous reset mid-SEND on word 1
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        word4(0, 16'h1234);
        tick();
        word4(1, 16'hABCD);
        #3;
        RST_n = 1'b0;
        #1;
        chk("ar_valid", 32'(valid4), 32'd0);
        chk("ar_busy", 32'(busy4), 32'd0);
        chk("ar_sel", 32'(sel4), 32'd0);
        chk("ar_idx", 32'(idx4), 32'd0);
        chk("ar_data", 32'(data4), 32'd0);
        #2;
        RST_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ar_idle_busy", 32'(busy4), 32'd0);
            chk("ar_idle_valid", 32'(valid4), 32'd0);
            chk("ar_idle_done", 32'(done4), 32'd0);
        end

        // Boundary: two registers of 0xFFFF
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("n2_busy", 32'(busy2), 32'd1);
        tick();
        chk("n2_w0_valid", 32'(valid2), 32'd1);
        chk("n2_w0_idx", 32'(idx2), 32'd0);
        chk("n2_w0_data", 32'(data2), 32'hFFFF);
        tick();
        chk("n2_gap_valid", 32'(valid2), 32'd0);
        tick();
        chk("n2_w1_idx", 32'(idx2), 32'd1);
        chk("n2_w1_data", 32'(data2), 32'hFFFF);
        chk("n2_w1_sel", 32'(sel2), 32'd1);
        tick();
        chk("n2_csum_valid", 32'(valid2), 32'd1);
        chk("n2_csum_last", 32'(last2), 32'd1);
        chk("n2_csum_data", 32'(data2), 32'h0000);
        chk("n2_csum_sel", 32'(sel2), 32'd1);
        tick();
        chk("n2_done", 32'(done2), 32'd1);
        chk("n2_end_sel", 32'(sel2), 32'd1);
        tick();
        chk("n2_idle_busy", 32'(busy2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
